// File: rtl/banked_regfile.sv
`default_nettype none
// ============================================================================
// Module   : banked_regfile
// Brief    : Multi-bank register file with two combinational read ports,
//            one synchronous write port and a bank-to-bank copy engine.
//            The core uses the copy engine for context save/restore.
// Revision : 1.0 - initial release
// ============================================================================
module banked_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int BANKS  = 2,
    localparam int BANK_W = (BANKS > 2) ? $clog2(BANKS) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [BANK_W-1:0] bank_sel,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] rs_data,
    input  logic              copy_start,
    input  logic [BANK_W-1:0] copy_src,
    input  logic [BANK_W-1:0] copy_dst,
    output logic              busy,
    output logic              copy_done
);

    localparam int c_depth = 2 ** ADDR_W;

    // Bank count widened by one bit so a plain compare flags out-of-range
    // bank numbers when BANKS is not a power of two.
    localparam logic [BANK_W:0] c_banks = (BANK_W + 1)'(BANKS);

    // Copy engine states
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_copy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [DATA_W-1:0] r_mem [BANKS][c_depth];

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [BANK_W-1:0] r_src;
    logic [BANK_W-1:0] r_dst;
    logic [ADDR_W-1:0] r_idx;

    logic w_sel_ok;
    logic w_src_ok;
    logic w_dst_ok;
    logic w_accept;
    logic w_copying;
    logic w_port_wr;

    assign w_sel_ok  = ({1'b0, bank_sel} < c_banks);
    assign w_src_ok  = ({1'b0, copy_src} < c_banks);
    assign w_dst_ok  = ({1'b0, copy_dst} < c_banks);

    // A request is only taken in IDLE and only for two valid banks; it is
    // never queued.
    assign w_accept  = (r_state == c_st_idle) && copy_start && w_src_ok && w_dst_ok;
    assign w_copying = (r_state == c_st_copy);

    // Port writes into the bank being filled are dropped so the copy result
    // is the only thing that lands in the destination.
    assign w_port_wr = w_en && w_sel_ok && !(w_copying && (bank_sel == r_dst));

    assign busy      = w_copying;
    assign copy_done = (r_state == c_st_done);

    // Zero-latency reads of the selected bank; no bypass of a pending write.
    assign rd_data = w_sel_ok ? r_mem[bank_sel][rd_addr] : '0;
    assign rs_data = w_sel_ok ? r_mem[bank_sel][rs_addr] : '0;

    // Copy engine state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Copy engine next-state: DEPTH copy cycles, then a single DONE cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = c_st_copy;
                end
            end
            c_st_copy: begin
                if (&r_idx) begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Latch the copy endpoints on acceptance and walk the register index
    always_ff @(posedge clock) begin
        if (reset) begin
            r_src <= '0;
            r_dst <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_src <= copy_src;
            r_dst <= copy_dst;
            r_idx <= '0;
        end else if (w_copying) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Register storage: port write plus one copied register per cycle. The
    // copy samples the source before this edge, so a same-cycle port write
    // to src[idx] is not seen by the copy but later source writes are.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int b = 0; b < BANKS; b++) begin
                for (int a = 0; a < c_depth; a++) begin
                    r_mem[b][a] <= '0;
                end
            end
        end else begin
            if (w_port_wr) begin
                r_mem[bank_sel][rd_addr] <= w_data;
            end
            if (w_copying) begin
                r_mem[r_dst][r_idx] <= r_mem[r_src][r_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_banked_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_banked_regfile
// Brief    : Scoreboard bench for banked_regfile: a default instance and a
//            DATA_W=16 / ADDR_W=3 / BANKS=3 instance, directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_banked_regfile;

    logic clock;
    logic reset;

    // Default instance (8-bit, 4 regs, 2 banks)
    logic        bank_sel0;
    logic [1:0]  rd_addr0, rs_addr0;
    logic [7:0]  w_data0;
    logic        w_en0;
    logic [7:0]  rd_data0, rs_data0;
    logic        copy_start0;
    logic        copy_src0, copy_dst0;
    logic        busy0, copy_done0;

    // Sweep instance (16-bit, 8 regs, 3 banks)
    logic [1:0]  bank_sel1;
    logic [2:0]  rd_addr1, rs_addr1;
    logic [15:0] w_data1;
    logic        w_en1;
    logic [15:0] rd_data1, rs_data1;
    logic        copy_start1;
    logic [1:0]  copy_src1, copy_dst1;
    logic        busy1, copy_done1;

    banked_regfile dut0 (
        .clock     (clock),
        .reset     (reset),
        .bank_sel  (bank_sel0),
        .rd_addr   (rd_addr0),
        .rs_addr   (rs_addr0),
        .w_data    (w_data0),
        .w_en      (w_en0),
        .rd_data   (rd_data0),
        .rs_data   (rs_data0),
        .copy_start(copy_start0),
        .copy_src  (copy_src0),
        .copy_dst  (copy_dst0),
        .busy      (busy0),
        .copy_done (copy_done0)
    );

    banked_regfile #(.DATA_W(16), .ADDR_W(3), .BANKS(3)) dut1 (
        .clock     (clock),
        .reset     (reset),
        .bank_sel  (bank_sel1),
        .rd_addr   (rd_addr1),
        .rs_addr   (rs_addr1),
        .w_data    (w_data1),
        .w_en      (w_en1),
        .rd_data   (rd_data1),
        .rs_data   (rs_data1),
        .copy_start(copy_start1),
        .copy_src  (copy_src1),
        .copy_dst  (copy_dst1),
        .busy      (busy1),
        .copy_done (copy_done1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          dut;
        logic [15:0] rd;
        logic [15:0] rs;
        logic        busy;
        logic        done;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    logic chk_valid;
    int   n_checks;
    int   n_fail;

    task automatic check_field(input string nm, input string fld,
                               input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    // Monitor: whenever a check is presented, pop the expectation and compare
    exp_t        m_e;
    logic [15:0] m_rd, m_rs;
    logic        m_busy, m_done;
    always @(negedge clock) begin
        if (chk_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_empty actual=0 required=1");
            end else begin
                m_e    = sb_q.pop_front();
                m_rd   = (m_e.dut == 0) ? {8'h00, rd_data0} : rd_data1;
                m_rs   = (m_e.dut == 0) ? {8'h00, rs_data0} : rs_data1;
                m_busy = (m_e.dut == 0) ? busy0 : busy1;
                m_done = (m_e.dut == 0) ? copy_done0 : copy_done1;
                check_field(m_e.name, "rd_data", m_rd, m_e.rd);
                check_field(m_e.name, "rs_data", m_rs, m_e.rs);
                check_field(m_e.name, "busy", {15'd0, m_busy}, {15'd0, m_e.busy});
                check_field(m_e.name, "copy_done", {15'd0, m_done}, {15'd0, m_e.done});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        chk_valid = 1'b0;
    endtask

    task automatic expect_out(input int d, input logic [15:0] erd, ers,
                              input logic eb, ed, input string nm);
        exp_t e;
        e.dut  = d;
        e.rd   = erd;
        e.rs   = ers;
        e.busy = eb;
        e.done = ed;
        e.name = nm;
        sb_q.push_back(e);
        chk_valid = 1'b1;
    endtask

    // One cycle on the default instance: drive, register expectation, clock
    task automatic cyc0(input logic b, input logic [1:0] ra, rsa,
                        input logic we, input logic [7:0] wd, input logic cs,
                        input logic [7:0] erd, ers, input logic eb, ed,
                        input string nm);
        bank_sel0   = b;
        rd_addr0    = ra;
        rs_addr0    = rsa;
        w_en0       = we;
        w_data0     = wd;
        copy_start0 = cs;
        expect_out(0, {8'h00, erd}, {8'h00, ers}, eb, ed, nm);
        tick();
        w_en0       = 1'b0;
        copy_start0 = 1'b0;
    endtask

    // One cycle on the sweep instance
    task automatic cyc1(input logic [1:0] b, input logic [2:0] ra, rsa,
                        input logic we, input logic [15:0] wd, input logic cs,
                        input logic [15:0] erd, ers, input logic eb, ed,
                        input string nm);
        bank_sel1   = b;
        rd_addr1    = ra;
        rs_addr1    = rsa;
        w_en1       = we;
        w_data1     = wd;
        copy_start1 = cs;
        expect_out(1, erd, ers, eb, ed, nm);
        tick();
        w_en1       = 1'b0;
        copy_start1 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        chk_valid   = 1'b0;
        reset       = 1'b1;
        bank_sel0   = 1'b0; rd_addr0 = '0; rs_addr0 = '0; w_data0 = '0; w_en0 = 1'b0;
        copy_start0 = 1'b0; copy_src0 = 1'b0; copy_dst0 = 1'b0;
        bank_sel1   = '0; rd_addr1 = '0; rs_addr1 = '0; w_data1 = '0; w_en1 = 1'b0;
        copy_start1 = 1'b0; copy_src1 = '0; copy_dst1 = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        cyc0(0, 0, 3, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, "rst_b0");
        cyc0(1, 1, 2, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, "rst_b1");
        cyc1(2, 7, 4, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, "rst_sweep_b2");

        // Port writes; each write cycle still reads the pre-write values
        cyc0(0, 0, 1, 1, 8'h11, 0, 8'h00, 8'h00, 0, 0, "wr_b0r0");
        cyc0(0, 1, 0, 1, 8'h22, 0, 8'h00, 8'h11, 0, 0, "wr_b0r1");
        cyc0(0, 2, 1, 1, 8'h33, 0, 8'h00, 8'h22, 0, 0, "wr_b0r2");
        cyc0(0, 3, 2, 1, 8'h44, 0, 8'h00, 8'h33, 0, 0, "same_cycle_old");
        cyc0(1, 2, 0, 1, 8'hA5, 0, 8'h00, 8'h00, 0, 0, "wr_b1r2");
        cyc0(0, 3, 0, 0, 8'h00, 0, 8'h44, 8'h11, 0, 0, "rd_b0_r3_r0");
        cyc0(1, 2, 0, 0, 8'h00, 0, 8'hA5, 8'h00, 0, 0, "rd_b1_r2_r0");
        cyc0(1, 1, 3, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, "rd_b1_r1_r3");

        // Copy 0 -> 1: 4 busy cycles, done on the 5th, restart request ignored
        copy_src0 = 1'b0; copy_dst0 = 1'b1;
        cyc0(0, 0, 1, 0, 8'h00, 1, 8'h11, 8'h22, 0, 0, "cp1_accept");
        cyc0(0, 2, 3, 0, 8'h00, 0, 8'h33, 8'h44, 1, 0, "cp1_c0");
        copy_src0 = 1'b1; copy_dst0 = 1'b0;
        cyc0(0, 2, 3, 0, 8'h00, 1, 8'h33, 8'h44, 1, 0, "cp1_c1_restart");
        copy_src0 = 1'b0; copy_dst0 = 1'b1;
        cyc0(0, 2, 3, 0, 8'h00, 0, 8'h33, 8'h44, 1, 0, "cp1_c2");
        cyc0(0, 2, 3, 0, 8'h00, 0, 8'h33, 8'h44, 1, 0, "cp1_c3");
        cyc0(0, 2, 3, 0, 8'h00, 0, 8'h33, 8'h44, 0, 1, "cp1_done");
        cyc0(1, 0, 1, 0, 8'h00, 0, 8'h11, 8'h22, 0, 0, "cp1_b1_lo");
        cyc0(1, 2, 3, 0, 8'h00, 0, 8'h33, 8'h44, 0, 0, "cp1_b1_hi");
        cyc0(1, 2, 3, 0, 8'h00, 0, 8'h33, 8'h44, 0, 0, "cp1_idle");

        // Give bank 1 r1 a distinct value before the collision copy
        cyc0(1, 1, 1, 1, 8'hEE, 0, 8'h22, 8'h22, 0, 0, "wr_b1r1_ee");
        cyc0(1, 1, 0, 0, 8'h00, 0, 8'hEE, 8'h11, 0, 0, "rd_b1r1_ee");

        // Copy 0 -> 1 with colliding port writes
        cyc0(0, 0, 1, 0, 8'h00, 1, 8'h11, 8'h22, 0, 0, "col_accept");
        cyc0(0, 0, 1, 1, 8'h77, 0, 8'h11, 8'h22, 1, 0, "col_idx0_src_wr");
        cyc0(0, 3, 0, 1, 8'h99, 0, 8'h44, 8'h77, 1, 0, "col_idx1_src_ahead");
        cyc0(1, 1, 0, 1, 8'hFF, 0, 8'h22, 8'h11, 1, 0, "col_idx2_dst_wr");
        cyc0(0, 3, 0, 0, 8'h00, 0, 8'h99, 8'h77, 1, 0, "col_idx3");
        cyc0(1, 1, 3, 0, 8'h00, 0, 8'h22, 8'h99, 0, 1, "col_done");
        cyc0(1, 0, 2, 0, 8'h00, 0, 8'h11, 8'h33, 0, 0, "col_b1_r0_r2");
        cyc0(0, 0, 3, 0, 8'h00, 0, 8'h77, 8'h99, 0, 0, "col_b0_r0_r3");

        // Reset on the 2nd COPY cycle aborts with no done pulse
        cyc0(0, 0, 3, 0, 8'h00, 1, 8'h77, 8'h99, 0, 0, "rmid_accept");
        cyc0(0, 0, 3, 0, 8'h00, 0, 8'h77, 8'h99, 1, 0, "rmid_c0");
        reset = 1'b1;
        cyc0(0, 0, 3, 0, 8'h00, 0, 8'h77, 8'h99, 1, 0, "rmid_c1_reset");
        reset = 1'b0;
        cyc0(0, 0, 3, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, "rmid_b0");
        cyc0(1, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, "rmid_b1_lo");
        cyc0(1, 2, 3, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, "rmid_b1_hi");
        cyc0(0, 1, 2, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, "rmid_b0_mid");

        // Sweep instance: fill bank 2, dirty bank 0 r5, copy 2 -> 0
        for (int i = 0; i < 8; i++) begin
            cyc1(2, 3'(i), 3'(i), 1, 16'h2100 + 16'(i), 0, 16'h0, 16'h0, 0, 0, "sw_wr_b2");
        end
        cyc1(0, 5, 5, 1, 16'hBEEF, 0, 16'h0, 16'h0, 0, 0, "sw_wr_b0r5");
        copy_src1 = 2'd2; copy_dst1 = 2'd0;
        cyc1(2, 0, 7, 0, 16'h0, 1, 16'h2100, 16'h2107, 0, 0, "sw_cp_accept");
        for (int i = 0; i < 8; i++) begin
            cyc1(2, 1, 6, 0, 16'h0, 0, 16'h2101, 16'h2106, 1, 0, "sw_cp_busy");
        end
        cyc1(2, 1, 6, 0, 16'h0, 0, 16'h2101, 16'h2106, 0, 1, "sw_cp_done");
        for (int k = 0; k < 4; k++) begin
            cyc1(0, 3'(2 * k), 3'(2 * k + 1), 0, 16'h0, 0,
                 16'h2100 + 16'(2 * k), 16'h2101 + 16'(2 * k), 0, 0, "sw_b0_after");
        end

        // Out-of-range bank: reads 0, writes ignored
        cyc1(3, 0, 7, 1, 16'hFFFF, 0, 16'h0, 16'h0, 0, 0, "sw_bad_bank_wr");
        cyc1(3, 0, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, "sw_bad_bank_rd");
        cyc1(1, 0, 7, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, "sw_b1_clean");
        cyc1(0, 0, 0, 0, 16'h0, 0, 16'h2100, 16'h2100, 0, 0, "sw_b0_clean");
        cyc1(2, 0, 0, 0, 16'h0, 0, 16'h2100, 16'h2100, 0, 0, "sw_b2_clean");

        // Copy requests naming an out-of-range bank are not accepted
        copy_src1 = 2'd0; copy_dst1 = 2'd3;
        cyc1(1, 0, 1, 0, 16'h0, 1, 16'h0, 16'h0, 0, 0, "sw_bad_dst_req");
        cyc1(1, 0, 1, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, "sw_bad_dst_idle");
        copy_src1 = 2'd3; copy_dst1 = 2'd1;
        cyc1(1, 0, 1, 0, 16'h0, 1, 16'h0, 16'h0, 0, 0, "sw_bad_src_req");
        cyc1(1, 0, 1, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, "sw_bad_src_idle");
        cyc1(1, 2, 7, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, "sw_bad_src_b1");

        tick();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
